gate_vector_gen: RTL and testbench

GATE_VECTOR_GEN -- requirements
Module: gate_vector_gen

---
 rtl/gate_vector_gen.sv | 147 ++++++++++++++
 tb/tb_gate_vector_gen.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_vector_gen.sv
// Operand-pair generator for a downstream bitwise gate stage.
// Emits an exhaustive or walking-one sequence under valid/ready handshake.
module gate_vector_gen #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 mode,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH:0]     count
);

    localparam int unsigned IW = 2 * WIDTH;
    localparam int unsigned CW = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q, index_d;
    logic [IW-1:0]   index_inc;
    logic [IW-1:0]   last_idx;
    logic            mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   count_q, count_d;
    logic            xfer;

    // Operand A for a given index under the given mode
    function automatic logic [WIDTH-1:0] vec_a(input logic m, input logic [IW-1:0] idx);
        if (m) return WIDTH'(1) << idx;
        return idx[IW-1:WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] vec_b(input logic m, input logic [IW-1:0] idx);
        if (m) return ~(WIDTH'(1) << idx);
        return idx[WIDTH-1:0];
    endfunction

    assign index_inc = index_q + IW'(1);
    assign last_idx  = mode_q ? IW'(WIDTH - 1) : {IW{1'b1}};

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = RUN;
                    index_d = '0;
                    count_d = '0;
                    mode_d  = mode;
                    a_d     = vec_a(mode, IW'(0));
                    b_d     = vec_b(mode, IW'(0));
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                xfer = valid_q && out_ready;
                if (xfer) count_d = count_q + CW'(1);
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    if (xfer && index_q != last_idx) index_d = index_inc;
                end else if (xfer && index_q == last_idx) begin
                    // index stays on the last vector rather than wrapping
                    state_d = DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (xfer) begin
                    index_d = index_inc;
                    a_d     = vec_a(mode_q, index_inc);
                    b_d     = vec_b(mode_q, index_inc);
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_gate_vector_gen.sv
// Bench for gate_vector_gen: scenario table with randomized handshake against
// a queue of expected vectors, plus hand-written reset and abort sequences.
module tb_gate_vector_gen;

    localparam int unsigned W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic           abort = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           busy;
    logic           done;
    logic [2*W:0]   count;

    int checks = 0;
    int errors = 0;

    gate_vector_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } vec_t;

    typedef struct {
        logic mode;
        int   ready_pct;
        int   abort_at;
        logic abort_rdy;
        int   exp_count;
        logic exp_done;
    } scen_t;

    vec_t  exp_q[$];
    scen_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Expected vector list straight from the sequence definitions
    task automatic build_model(input logic m);
        vec_t v;
        exp_q.delete();
        if (m == 1'b0) begin
            for (int i = 0; i < (1 << (2 * W)); i++) begin
                v.a = W'(i / (1 << W));
                v.b = W'(i % (1 << W));
                exp_q.push_back(v);
            end
        end else begin
            for (int k = 0; k < int'(W); k++) begin
                v.a = W'(1 << k);
                v.b = ~W'(1 << k);
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic run_seq(input scen_t s);
        int xfers;
        int cyc;
        logic rdy;
        logic [W-1:0] la;
        logic [W-1:0] lb;
        xfers = 0;
        cyc = 0;
        la = '0;
        lb = '0;
        build_model(s.mode);
        @(negedge clk);
        start = 1'b1;
        mode = s.mode;
        abort = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("busy_run", 32'(busy), 32'd1);
        chk("count_cleared", 32'(count), 32'd0);
        while (out_valid && cyc < 5000) begin
            cyc++;
            if (exp_q.size() == 0) begin
                fail("extra_vector");
                break;
            end
            chk("vec_a", 32'(a), 32'(exp_q[0].a));
            chk("vec_b", 32'(b), 32'(exp_q[0].b));
            la = a;
            lb = b;
            rdy = ($urandom_range(99) < 32'(s.ready_pct));
            mode = 1'($urandom);
            start = ($urandom_range(7) == 0);
            if (s.abort_at >= 0 && xfers == s.abort_at) begin
                abort = 1'b1;
                rdy = s.abort_rdy;
            end
            out_ready = rdy;
            if (rdy) begin
                xfers++;
                void'(exp_q.pop_front());
            end
            @(negedge clk);
        end
        if (cyc >= 5000) fail("timeout");
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        chk("done_pulse", 32'(done), 32'(s.exp_done));
        chk("busy_end", 32'(busy), 32'd0);
        chk("count_end", 32'(count), 32'(s.exp_count));
        chk("xfers", 32'(xfers), 32'(s.exp_count));
        chk("a_hold", 32'(a), 32'(la));
        chk("b_hold", 32'(b), 32'(lb));
        if (s.abort_at < 0) chk("model_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("count_hold", 32'(count), 32'(s.exp_count));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        tbl[0] = '{mode: 1'b0, ready_pct: 100, abort_at: -1, abort_rdy: 1'b0, exp_count: 256, exp_done: 1'b1};
        tbl[1] = '{mode: 1'b1, ready_pct: 100, abort_at: -1, abort_rdy: 1'b0, exp_count: 4,   exp_done: 1'b1};
        tbl[2] = '{mode: 1'b0, ready_pct: 50,  abort_at: -1, abort_rdy: 1'b0, exp_count: 256, exp_done: 1'b1};
        tbl[3] = '{mode: 1'b1, ready_pct: 40,  abort_at: -1, abort_rdy: 1'b0, exp_count: 4,   exp_done: 1'b1};
        tbl[4] = '{mode: 1'b0, ready_pct: 70,  abort_at: 10, abort_rdy: 1'b0, exp_count: 10,  exp_done: 1'b0};
        tbl[5] = '{mode: 1'b1, ready_pct: 60,  abort_at: 2,  abort_rdy: 1'b1, exp_count: 3,   exp_done: 1'b0};

        #2 rst_n = 1'b0;
        #1;
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_b", 32'(b), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_rst", 32'(out_valid), 32'd0);
        end

        for (int i = 0; i < 6; i++) run_seq(tbl[i]);

        // start together with abort in IDLE begins a sequence
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        mode = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_valid", 32'(out_valid), 32'd1);
        chk("start_abort_a", 32'(a), 32'd0);
        chk("start_abort_b", 32'(b), 32'd0);
        chk("start_abort_count", 32'(count), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_count", 32'(count), 32'd0);

        // reset asserted while vector (3,7) is presented
        @(negedge clk);
        start = 1'b1;
        mode = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(out_valid && a == W'(3) && b == W'(7)) && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (cyc >= 200) fail("reach_3_7_timeout");
        chk("pre_rst_count", 32'(count), 32'd55);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_a", 32'(a), 32'd0);
        chk("mid_rst_b", 32'(b), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(count), 32'd0);
        #2 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle_valid", 32'(out_valid), 32'd0);
            chk("post_rst_idle_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b0;
        run_seq(tbl[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
